// File: rtl/muldiv_stall_ctrl.sv
// rtl/muldiv_stall_ctrl.sv - mul/div sequencer: start pulse, latency count, pipeline stall, one-shot result valid
// Optional macro MULDIV_EARLY_OUT_EN: early_done_i in BUSY completes the operation ahead of the counter.
module muldiv_stall_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             flush_i,
    input  logic             stall_ext_i,
    input  logic             early_done_i,
    output logic             dp_start_o,
    output logic             dp_kill_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             finish;

`ifndef MULDIV_EARLY_OUT_EN
    logic unused_early_done;
    assign unused_early_done = early_done_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        finish         = 1'b0;
        dp_start_o     = 1'b0;
        dp_kill_o      = 1'b0;
        stall_o        = 1'b0;
        busy_o         = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rst_i gates the accept path so outputs drop the instant reset rises
                if (start_i && !flush_i && !rst_i) begin
                    dp_start_o = 1'b1;
                    stall_o    = 1'b1;
                    cnt_d      = is_div_i ? DIV_LOAD : MUL_LOAD;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    dp_kill_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    finish  = (cnt_q == '0);
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_done_i) begin
                        finish = 1'b1;
                    end
`endif
                    if (finish) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                // start_i here belongs to the instruction already leaving Execute
                result_valid_o = 1'b1;
                if (flush_i || !stall_ext_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// tb/tb_muldiv_stall_ctrl.sv - scoreboard bench for muldiv_stall_ctrl against a timing-arithmetic reference
module tb_muldiv_stall_ctrl;

    localparam int MULN = 3;
    localparam int DIVN = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, is_div = 1'b0, flush = 1'b0, sext = 1'b0, early = 1'b0;
    logic       dp_start, dp_kill, stall, busy, rvalid;
    logic [5:0] cnt;

    muldiv_stall_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .is_div_i(is_div), .flush_i(flush),
        .stall_ext_i(sext), .early_done_i(early), .dp_start_o(dp_start), .dp_kill_o(dp_kill),
        .stall_o(stall), .busy_o(busy), .result_valid_o(rvalid), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic       k;
        logic       st;
        logic       b;
        logic       rv;
        logic [5:0] c;
    } out_t;

    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: 0 = idle, 1 = operation running since cycle t0 for n cycles, 2 = result presented
    int   mmode = 0;
    int   t0 = 0;
    int   n = 0;
    int   cyc = 0;

    function automatic out_t actual();
        out_t a;
        a = '{s: dp_start, k: dp_kill, st: stall, b: busy, rv: rvalid, c: cnt};
        return a;
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got s=%b k=%b st=%b b=%b rv=%b cnt=%0d exp s=%b k=%b st=%b b=%b rv=%b cnt=%0d",
                     name, cyc, a.s, a.k, a.st, a.b, a.rv, a.c, e.s, e.k, e.st, e.b, e.rv, e.c);
        end
    endtask

    task automatic drive(input logic st_i, input logic dv_i, input logic fl_i, input logic se_i, input logic ed_i);
        out_t e;
        int   el;
        bit   done_now;
        @(posedge clk);
        #1;
        start = st_i; is_div = dv_i; flush = fl_i; sext = se_i; early = ed_i;
        e = '0;
        case (mmode)
            0: if (st_i && !fl_i) begin
                e.s = 1'b1; e.st = 1'b1;
                t0 = cyc; n = dv_i ? DIVN : MULN; mmode = 1;
            end
            1: begin
                el = cyc - t0;
                e.b = 1'b1;
                e.c = 6'(n - el);
                if (fl_i) begin
                    e.k = 1'b1; mmode = 0;
                end else begin
                    e.st = 1'b1;
                    done_now = (el == n);
`ifdef MULDIV_EARLY_OUT_EN
                    if (ed_i) done_now = 1'b1;
`endif
                    if (done_now) mmode = 2;
                end
            end
            default: begin
                e.rv = 1'b1;
                if (fl_i || !se_i) mmode = 0;
            end
        endcase
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        start = 1'b1;
        rst = 1'b1;
        #1;
        check("async_reset", actual(), '0);
        start = 1'b0; flush = 1'b0; sext = 1'b0; early = 1'b0;
        #1;
        rst = 1'b0;
        mmode = 0;
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", actual(), e);
                if (dp_start && dp_kill) begin
                    miscompares++;
                    $display("FAIL start_kill_overlap cyc=%0d got both high, required exclusive", cyc);
                end
            end
        end
    end

    initial begin : stim
        #2;
        check("reset_state", actual(), '0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        // MUL
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        // DIV
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(36);
        // flush mid-DIV at T+10
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(9);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        // held result with start during DONE
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // async reset mid-DIV, then a normal MUL
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        reset_pulse();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        // early-done at T+2
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(35);
        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse();
            drive(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                  ($urandom % 2) == 1, ($urandom % 8) == 0);
        end
        idle(1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_stall_ctrl.md
Name: muldiv_stall_ctrl

Overview:
- Sequencer for the multi-cycle multiply/divide unit in the Execute stage of the Aquila RV32IM core.
- Accepts a mul/div issue from the Decode_Execute pipeline register, pulses the datapath start, and counts the operation latency.
- Holds stall_o for the whole operation, so the program counter and the IF/ID, ID/EX and EX/MEM registers freeze. It then presents a one-shot result-valid to writeback.
- Kills an in-flight operation on a pipeline flush (sys_jump / flush2exe).

Parameters:
- MUL_CYCLES, 3, datapath latency of MUL/MULH/MULHSU/MULHU in cycles; must be >= 1.
- DIV_CYCLES, 32, datapath latency of DIV/DIVU/REM/REMU in cycles; must be >= 1.
- CNT_W, 6, down-counter width; must hold max(MUL_CYCLES, DIV_CYCLES) - 1.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  valid mul/div instruction present in Execute (from ID/EX register)
- is_div_i  in  1  1 = div/rem, 0 = mul; sampled only when the start is accepted
- flush_i  in  1  flush of the Execute stage (sys_jump); kills the operation
- stall_ext_i  in  1  downstream memory stall; blocks result hand-off
- early_done_i  in  1  datapath early completion (used only with MULDIV_EARLY_OUT_EN)
- dp_start_o  out  1  one-cycle start pulse to the mul/div datapath
- dp_kill_o  out  1  one-cycle abort pulse to the mul/div datapath
- stall_o  out  1  pipeline stall request (OR-ed with the hazard stall at core level)
- busy_o  out  1  operation in flight (state BUSY)
- result_valid_o  out  1  datapath result valid, writeback may capture
- cnt_o  out  CNT_W  remaining count, for debug

Behaviour:
Interface fixed: one clock (clk_i); reset rst_i is asynchronous, active-high.

Reset:
- state = IDLE, counter = 0.
- All outputs 0.
- Reset asserted mid-operation aborts the operation silently; dp_kill_o is not pulsed.

States: IDLE, BUSY, DONE.

IDLE:
- start_i=1 and flush_i=0: accept the operation.
  - dp_start_o=1 and stall_o=1 (combinational, same cycle).
  - counter <= (is_div_i ? DIV_CYCLES : MUL_CYCLES) - 1.
  - Next state BUSY.
- start_i=1 and flush_i=1: start is ignored; remain in IDLE with all outputs 0.

BUSY:
- stall_o=1, busy_o=1.
- flush_i=1 has priority over everything: dp_kill_o=1, stall_o=0 in the same cycle, counter <= 0, next state IDLE.
- Otherwise, counter==0: next state DONE. Else counter decrements by 1.

DONE:
- result_valid_o=1, stall_o=0.
- stall_ext_i=0: next state IDLE.
- stall_ext_i=1: remain in DONE with result_valid_o held high. stall_o stays 0; the external stall freezes the pipeline.
- flush_i=1: next state IDLE, result_valid_o still 1 this cycle. Core gating of the writeback is the flush's responsibility.
- start_i is ignored in DONE, because it is the same instruction leaving Execute. A back-to-back mul/div is accepted in the following IDLE cycle.

Latency:
- Start accepted at cycle T; operation length N.
- stall_o is high for cycles T through T+N, i.e. N+1 cycles.
- result_valid_o first rises at T+N+1.

Other rules:
- The counter never wraps.
- cnt_o mirrors the counter.
- dp_start_o and dp_kill_o are never high in the same cycle.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in BUSY, early_done_i=1 (and flush_i=0) forces next state DONE regardless of the counter, with counter <= 0. This serves divide-by-zero and zero operands. early_done_i is ignored in IDLE and DONE.
- Undefined: early_done_i is ignored entirely; latency is always fixed at N+1 stall cycles.

Test Plan:
- MUL, default parameters: start_i=1, is_div_i=0 at T -> dp_start_o=1 at T; stall_o=1 during T..T+3; result_valid_o=1 at T+4 only; back in IDLE at T+5.
- DIV: start_i=1, is_div_i=1 at T -> stall_o=1 for 33 cycles (T..T+32); cnt_o counts 31 down to 0; result_valid_o=1 at T+33.
- Flush mid-DIV: flush_i=1 at T+10 -> dp_kill_o=1 and stall_o=0 at T+10; IDLE at T+11; result_valid_o never asserted.
- Held result: stall_ext_i=1 during T+4..T+6 of a MUL -> result_valid_o=1 for T+4..T+7; IDLE at T+8; start_i during DONE ignored (no second dp_start_o).
- Async reset: rst_i pulsed between clock edges at T+5 of a DIV -> all outputs 0 immediately, without waiting for a clock edge; next start_i is accepted normally.
- MULDIV_EARLY_OUT_EN defined: DIV start at T, early_done_i=1 at T+2 -> DONE at T+3 with result_valid_o=1. Same stimulus with the macro undefined -> result_valid_o at T+33.
